// File: rtl/vga_term_pkg.sv
// Shared character codes and controller states for the VGA text-terminal writer.
package vga_term_pkg;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    CLR_SCREEN = 2'd0,
    IDLE       = 2'd1,
    CLR_LINE   = 2'd2
  } term_state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CH_PRINT_LO) && (b <= CH_PRINT_HI);
  endfunction

endpackage

// File: rtl/vga_term_writer.sv
// Byte-stream text terminal: turns ASCII bytes into one-cell-per-cycle writes into the
// VGA character buffer, tracking a cursor and blanking rows/screen before reuse.
module vga_term_writer #(
  parameter int COLS            = 8,
  parameter int ROWS            = 8,
  parameter int DATA_ADDR_WIDTH = 6
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [7:0]                 IN_DATA,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  output logic [DATA_ADDR_WIDTH-1:0] DATA_ADDR,
  output logic [7:0]                 DATA_OUT,
  output logic                       WR_EN,
  output logic [$clog2(ROWS)-1:0]    CURSOR_ROW,
  output logic [$clog2(COLS)-1:0]    CURSOR_COL,
  output logic                       BUSY
);
  import vga_term_pkg::*;

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int CELLS = COLS * ROWS;
  localparam int FW    = $clog2(CELLS + 1);

  if (DATA_ADDR_WIDTH < $clog2(CELLS)) begin : g_addr_width_check
    $error("DATA_ADDR_WIDTH too small for COLS*ROWS cells");
  end

  term_state_t                state_q;
  logic [RW-1:0]              row_q;
  logic [CW-1:0]              col_q;
  logic [FW-1:0]              fill_q;
  logic                       wr_en_q;
  logic [DATA_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                 data_q;
  logic                       ready_q;
  logic                       busy_q;

  logic                       accept_d;
  logic                       last_col_d;
  logic [RW-1:0]              row_next_d;
  logic [DATA_ADDR_WIDTH-1:0] cur_addr_d;

  function automatic logic [DATA_ADDR_WIDTH-1:0] addr_of(input logic [RW-1:0] r,
                                                         input logic [CW-1:0] c);
    return DATA_ADDR_WIDTH'(r) * DATA_ADDR_WIDTH'(COLS) + DATA_ADDR_WIDTH'(c);
  endfunction

  assign accept_d   = IN_VALID && ready_q;
  assign last_col_d = (col_q == CW'(COLS - 1));
  // Bottom wrap returns to row 0; the buffer cannot be read back, so no scrolling.
  assign row_next_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
  assign cur_addr_d = addr_of(row_q, col_q);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= CLR_SCREEN;
      row_q   <= '0;
      col_q   <= '0;
      fill_q  <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        CLR_SCREEN: begin
          if (fill_q == FW'(CELLS)) begin
            state_q <= IDLE;
            fill_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            wr_en_q <= 1'b1;
            addr_q  <= DATA_ADDR_WIDTH'(fill_q);
            data_q  <= CH_SPACE;
            fill_q  <= fill_q + FW'(1);
          end
        end
        CLR_LINE: begin
          if (fill_q == FW'(COLS)) begin
            state_q <= IDLE;
            fill_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            wr_en_q <= 1'b1;
            addr_q  <= addr_of(row_q, CW'(fill_q));
            data_q  <= CH_SPACE;
            fill_q  <= fill_q + FW'(1);
          end
        end
        IDLE: begin
          if (accept_d) begin
            if (is_printable(IN_DATA)) begin
              wr_en_q <= 1'b1;
              addr_q  <= cur_addr_d;
              data_q  <= IN_DATA;
              if (last_col_d) begin
                row_q   <= row_next_d;
                col_q   <= '0;
                fill_q  <= '0;
                state_q <= CLR_LINE;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
              end else begin
                col_q <= col_q + CW'(1);
              end
            end else begin
              case (IN_DATA)
                CH_CR: col_q <= '0;
                CH_LF: begin
                  // No character to write, so column 0 of the new row is blanked right away.
                  row_q   <= row_next_d;
                  col_q   <= '0;
                  wr_en_q <= 1'b1;
                  addr_q  <= addr_of(row_next_d, '0);
                  data_q  <= CH_SPACE;
                  fill_q  <= FW'(1);
                  state_q <= CLR_LINE;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                end
                CH_BS: begin
                  if (col_q != '0) begin
                    wr_en_q <= 1'b1;
                    addr_q  <= cur_addr_d - DATA_ADDR_WIDTH'(1);
                    data_q  <= CH_SPACE;
                    col_q   <= col_q - CW'(1);
                  end
                end
                CH_FF: begin
                  row_q   <= '0;
                  col_q   <= '0;
                  fill_q  <= '0;
                  state_q <= CLR_SCREEN;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        default: begin
          state_q <= CLR_SCREEN;
          fill_q  <= '0;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign IN_READY   = ready_q;
  assign DATA_ADDR  = addr_q;
  assign DATA_OUT   = data_q;
  assign WR_EN      = wr_en_q;
  assign CURSOR_ROW = row_q;
  assign CURSOR_COL = col_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_vga_term_writer.sv
// Bench for vga_term_writer: byte vectors with expected cursor/stall, writes checked via scoreboard.
module tb_vga_term_writer;
  localparam int COLS  = 8;
  localparam int ROWS  = 8;
  localparam int AW    = 6;
  localparam int CELLS = COLS * ROWS;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [7:0]    IN_DATA;
  logic          IN_VALID;
  logic          IN_READY;
  logic [AW-1:0] DATA_ADDR;
  logic [7:0]    DATA_OUT;
  logic          WR_EN;
  logic [2:0]    CURSOR_ROW;
  logic [2:0]    CURSOR_COL;
  logic          BUSY;

  vga_term_writer #(.COLS(COLS), .ROWS(ROWS), .DATA_ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RESET(RESET), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .DATA_ADDR(DATA_ADDR), .DATA_OUT(DATA_OUT), .WR_EN(WR_EN),
    .CURSOR_ROW(CURSOR_ROW), .CURSOR_COL(CURSOR_COL), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [7:0] b; int row; int col; int lo; } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   mr = 0;
  int   mc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge CLK) begin : mon
    wr_t e;
    if (RESET === 1'b0 && WR_EN === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%02h, no write expected", DATA_ADDR, DATA_OUT);
      end else begin
        e = exp_q.pop_front();
        if (DATA_ADDR !== e.addr || DATA_OUT !== e.data) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                   DATA_ADDR, DATA_OUT, e.addr, e.data);
        end
      end
    end
  end

  function automatic void push_wr(input int a, input logic [7:0] d);
    wr_t e;
    e.addr = AW'(a);
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void model_adv();
    mr = (mr == ROWS - 1) ? 0 : mr + 1;
    mc = 0;
    for (int c = 0; c < COLS; c++) push_wr(mr * COLS + c, 8'h20);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(mr * COLS + mc, b);
      if (mc < COLS - 1) mc++;
      else model_adv();
    end else if (b == 8'h0D) begin
      mc = 0;
    end else if (b == 8'h0A) begin
      model_adv();
    end else if (b == 8'h08) begin
      if (mc > 0) begin
        push_wr(mr * COLS + mc - 1, 8'h20);
        mc--;
      end
    end else if (b == 8'h0C) begin
      for (int i = 0; i < CELLS; i++) push_wr(i, 8'h20);
      mr = 0;
      mc = 0;
    end
  endfunction

  function automatic void add_vec(input logic [7:0] b, input int r, input int c, input int lo);
    vec_t v;
    v.b = b; v.row = r; v.col = c; v.lo = lo;
    vecs.push_back(v);
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (IN_READY !== 1'b1 && n < 300) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic send_vec(input vec_t v);
    int n;
    wait_ready(n);
    if (IN_READY !== 1'b1) check("ready_timeout", {31'd0, IN_READY}, 1);
    IN_DATA  = v.b;
    IN_VALID = 1'b1;
    model_byte(v.b);
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN_DATA  = 8'($urandom);
    check($sformatf("cursor_row[%02h]", v.b), CURSOR_ROW, v.row);
    check($sformatf("cursor_col[%02h]", v.b), CURSOR_COL, v.col);
    check($sformatf("busy[%02h]", v.b), BUSY, (v.lo != 0));
    wait_ready(n);
    check($sformatf("ready_low_cycles[%02h]", v.b), n, v.lo);
  endtask

  // Called at the negedge where RESET is released.
  task automatic expect_full_clear();
    int n;
    exp_q.delete();
    mr = 0;
    mc = 0;
    for (int i = 0; i < CELLS; i++) push_wr(i, 8'h20);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("clear_cycles", n, CELLS);
    check("ready_during_last_clear", IN_READY, 0);
    check("busy_during_last_clear", BUSY, 1);
    @(negedge CLK);
    check("ready_after_clear", IN_READY, 1);
    check("busy_after_clear", BUSY, 0);
    check("row_after_clear", CURSOR_ROW, 0);
    check("col_after_clear", CURSOR_COL, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RESET    = 1'b1;
    IN_VALID = 1'b0;
    IN_DATA  = 8'h00;
    repeat (3) @(negedge CLK);
    check("rst_wr_en", WR_EN, 0);
    check("rst_addr", DATA_ADDR, 0);
    check("rst_data", DATA_OUT, 0);
    check("rst_ready", IN_READY, 0);
    check("rst_busy", BUSY, 1);
    check("rst_row", CURSOR_ROW, 0);
    check("rst_col", CURSOR_COL, 0);
    RESET = 1'b0;
    expect_full_clear();

    add_vec("A", 0, 1, 0);
    add_vec("B", 0, 2, 0);
    for (int r = 1; r < ROWS; r++) add_vec(8'h0A, r, 0, 8);
    for (int c = 1; c < COLS; c++) add_vec("x", 7, c, 0);
    add_vec("x", 0, 0, 9);
    add_vec(8'h08, 0, 0, 0);
    add_vec("a", 0, 1, 0);
    add_vec("b", 0, 2, 0);
    add_vec("c", 0, 3, 0);
    add_vec(8'h08, 0, 2, 0);
    add_vec(8'h0D, 0, 0, 0);
    add_vec(8'h7F, 0, 0, 0);
    add_vec(8'h1F, 0, 0, 0);
    add_vec(8'h7E, 0, 1, 0);
    add_vec(8'h20, 0, 2, 0);
    for (int i = 0; i < vecs.size(); i++) send_vec(vecs[i]);

    // LF into row 1, then reset while the row fill is at column 3.
    IN_DATA  = 8'h0A;
    IN_VALID = 1'b1;
    model_byte(8'h0A);
    @(negedge CLK);
    IN_VALID = 1'b0;
    n = 0;
    while (!(WR_EN === 1'b1 && DATA_ADDR === AW'(COLS + 3)) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("fill_col3_reached", n, 3);
    #2 RESET = 1'b1;
    #1;
    check("midline_rst_wr_en", WR_EN, 0);
    check("midline_rst_busy", BUSY, 1);
    check("midline_rst_ready", IN_READY, 0);
    check("midline_rst_row", CURSOR_ROW, 0);
    exp_q.delete();
    @(negedge CLK);
    RESET = 1'b0;
    expect_full_clear();

    vecs.delete();
    add_vec("Q", 0, 1, 0);
    add_vec(8'h0C, 0, 0, CELLS + 1);
    add_vec(8'h07, 0, 0, 0);
    add_vec("Z", 0, 1, 0);
    for (int i = 0; i < vecs.size(); i++) send_vec(vecs[i]);

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
